mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipelined core. It arbitrates requests and issues one transaction at a time to the memory. It then routes the response back to the originating port with a one-cycle valid pulse. The data port has priority, and a starvation counter guarantees forward progress of instruction fetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data grants made while i_req is pending before instruction fetch is forced to win (range 1..15)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
i_req  in  1  fetch request; held high until i_valid
i_addr  in  ADDR_W  fetch address; stable while i_req is high
i_rdata  out  DATA_W  fetched instruction; meaningful only when i_valid=1
i_valid  out  1  one-cycle pulse: fetch complete
d_req  in  1  data request; held high until d_valid
d_addr  in  ADDR_W  data address; stable while d_req is high
d_wdata  in  DATA_W  store data
d_we  in  1  1=store, 0=load; stable while d_req is high
d_rdata  out  DATA_W  load data; meaningful only when d_valid=1
d_valid  out  1  one-cycle pulse: data access complete (load or store)
m_req  out  1  memory request
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_we  out  1  memory write enable
m_ready  in  1  memory accepts the request this cycle (m_req & m_ready)
m_rvalid  in  1  memory response; one per accepted request, including writes
m_rdata  in  DATA_W  memory read data
busy  out  1  a transaction is outstanding (state is not IDLE)

Behaviour:
- FSM states: IDLE, I_WAIT, D_WAIT. Exactly one outstanding transaction at any time.
- Reset (reset_n=0 at a clk edge):
  - state goes to IDLE and the starvation counter goes to 0.
  - i_valid, d_valid, busy read 0 after that edge.
  - i_rdata and d_rdata registers are cleared to 0.
  - A transaction in flight is abandoned; its later m_rvalid is ignored.
- IDLE grant selection (combinational in the same cycle):
  - Only d_req high: select data.
  - Only i_req high: select instruction.
  - Both high: select data, unless the counter equals STARVE_LIMIT, in which case select instruction.
  - Neither high: m_req=0.
- IDLE issue:
  - m_req=1, and m_addr, m_we, m_wdata are taken from the selected port.
  - For instruction fetches, m_we=0 and m_wdata=0.
  - When m_ready=0, remain in IDLE and re-arbitrate next cycle. A grant is not sticky until accepted.
  - When m_ready=1, go to I_WAIT or D_WAIT.
- I_WAIT / D_WAIT:
  - m_req=0, m_we=0.
  - On m_rvalid=1, register m_rdata into i_rdata or d_rdata, pulse the matching valid for exactly the next cycle, and return to IDLE.
  - Latency: request acceptance to valid pulse is (memory latency + 1) cycles.
  - No new issue occurs in the cycle the valid pulse is visible. The requester may keep its req high for a new access.
- Valid timing: a valid pulse is registered, so it is high in the cycle after m_rvalid. i_rdata and d_rdata hold their value until the next completion on the same port.
- Stray response: m_rvalid while in IDLE is ignored and no valid pulse is generated.
- Starvation counter (4-bit):
  - Increments (saturating at STARVE_LIMIT) on each accepted data request while i_req=1.
  - Clears to 0 on each accepted instruction request.
  - Clears to 0 on any IDLE cycle with i_req=0.
- A requester dropping req while its own transaction is outstanding does not cancel it; the valid pulse still occurs.
- busy = (state != IDLE).
- Properties: never two requests outstanding; never both valids in the same cycle; i_valid and d_valid are never asserted without a preceding acceptance from the same port.

Test Plan:
1. Reset, then i_req=1, i_addr=0x100, m_ready=1, memory latency 1 with m_rdata=0x00500093 -> m_req/m_addr=0x100 in cycle 0; i_valid=1 with i_rdata=0x00500093 in cycle 2; d_valid stays 0.
2. i_req and d_req both high in the same cycle, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> data issued first with m_we=1 and m_wdata=0xDEADBEEF; d_valid pulses; instruction then issued; i_valid follows.
3. d_req held high continuously with i_req=1 and STARVE_LIMIT=4 -> 4 data grants, then the 5th grant goes to instruction and the counter reads 0.
4. m_ready=0 for 3 cycles with d_req=1 -> m_req stays high with stable d_addr; busy=0; no valid pulse until m_ready=1.
5. reset_n=0 while in D_WAIT, then m_rvalid=1 two cycles after reset release -> state IDLE; d_valid and i_valid stay 0; d_rdata=0.
6. Load at 0x40 returning 0x12345678, then d_req dropped mid-wait -> d_valid pulses once with d_rdata=0x12345678; busy clears in the same cycle d_valid rises.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              d_we,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              m_req,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_we,
   input  logic              m_ready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t            state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              i_valid_q, i_valid_d;
   logic              d_valid_q, d_valid_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_i, grant_d;

   // Grant selection, memory request drive and next-state logic.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      i_valid_d    = 1'b0;
      d_valid_d    = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      grant_i      = 1'b0;
      grant_d      = 1'b0;
      m_req        = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
      m_we         = 1'b0;

      case (state_q)
         IDLE: begin
            if (!i_req) begin
               starve_cnt_d = 4'd0;
            end else begin
               starve_cnt_d = starve_cnt_q;
            end
            // No issue while a completion pulse is visible; a held req is a new access.
            if (!(i_valid_q || d_valid_q)) begin
               if (d_req && !(i_req && (starve_cnt_q == LIMIT))) begin
                  grant_d = 1'b1;
               end else if (i_req) begin
                  grant_i = 1'b1;
               end else begin
                  grant_d = 1'b0;
               end
            end else begin
               grant_d = 1'b0;
            end

            if (grant_d) begin
               m_req   = 1'b1;
               m_addr  = d_addr;
               m_wdata = d_wdata;
               m_we    = d_we;
               if (m_ready) begin
                  state_d = D_WAIT;
                  if (i_req && (starve_cnt_q != LIMIT)) begin
                     starve_cnt_d = starve_cnt_q + 4'd1;
                  end else begin
                     starve_cnt_d = starve_cnt_d;
                  end
               end else begin
                  state_d = IDLE;
               end
            end else if (grant_i) begin
               m_req  = 1'b1;
               m_addr = i_addr;
               if (m_ready) begin
                  state_d      = I_WAIT;
                  starve_cnt_d = 4'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               m_req = 1'b0;
            end
         end
         I_WAIT: begin
            if (m_rvalid) begin
               i_rdata_d = m_rdata;
               i_valid_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = I_WAIT;
            end
         end
         D_WAIT: begin
            if (m_rvalid) begin
               d_rdata_d = m_rdata;
               d_valid_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = D_WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         i_valid_q    <= 1'b0;
         d_valid_q    <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         i_valid_q    <= i_valid_d;
         d_valid_q    <= d_valid_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign i_valid = i_valid_q;
   assign d_valid = d_valid_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign busy    = (state_q != IDLE);

endmodule
